// File: rtl/hawk_sector_reader.sv
// Read-side sector serializer: fetches one sector from the cylinder cache and shifts it out MSB-first.
// Optional checksum verification is compiled in with `define HAWK_READ_CHECKSUM_EN.
module hawk_sector_reader #(
  parameter int         PREAMBLE_BYTES  = 8,
  parameter logic [7:0] SYNC_BYTE       = 8'h01,
  parameter int         SECTOR_BYTES    = 402,
  parameter int         POSTAMBLE_BYTES = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        bit_en_i,
  input  logic        sector_pulse_i,
  input  logic        read_gate_i,
  input  logic [1:0]  head_i,
  input  logic [3:0]  sector_i,
  output logic [14:0] cache_addr_o,
  input  logic [7:0]  cache_q_i,
  output logic        read_data_o,
  output logic        read_valid_o,
  output logic        busy_o,
  output logic        sector_overrun_o,
  output logic        checksum_err_o
);

  localparam logic [8:0] PRE_LAST  = 9'(PREAMBLE_BYTES - 1);
  localparam logic [8:0] SECT_LAST = 9'(SECTOR_BYTES - 1);
  localparam logic [8:0] POST_LAST = 9'(POSTAMBLE_BYTES - 1);

  typedef enum logic [2:0] {IDLE, PREAMBLE, SYNC, DATA, POST} state_t;

  state_t      state_q, state_d;
  logic        pulse_q;
  logic [1:0]  head_q, head_d;
  logic [3:0]  sector_q, sector_d;
  logic [8:0]  byte_idx_q, byte_idx_d;
  logic [8:0]  byte_cnt_q, byte_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        overrun_q, overrun_d;

  logic        start_edge;
  logic        start;
  logic        byte_end;
  logic [8:0]  byte_idx_inc;

  assign start_edge   = sector_pulse_i & ~pulse_q;
  assign start        = start_edge & read_gate_i & (state_q == IDLE);
  assign byte_end     = bit_en_i & read_gate_i & (bit_cnt_q == 3'd7);
  assign byte_idx_inc = (byte_idx_q == SECT_LAST) ? byte_idx_q : byte_idx_q + 9'd1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      pulse_q    <= 1'b0;
      head_q     <= '0;
      sector_q   <= '0;
      byte_idx_q <= '0;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pulse_q    <= sector_pulse_i;
      head_q     <= head_d;
      sector_q   <= sector_d;
      byte_idx_q <= byte_idx_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    sector_d   = sector_q;
    byte_idx_d = byte_idx_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    // An edge that arrives while a sector is in flight, including on its final bit, is dropped.
    overrun_d  = start_edge & (state_q != IDLE);

    if (state_q == IDLE) begin
      if (start) begin
        state_d    = PREAMBLE;
        head_d     = head_i;
        sector_d   = sector_i;
        byte_idx_d = '0;
        byte_cnt_d = '0;
        bit_cnt_d  = '0;
        shift_d    = '0;
      end
    end else if (!read_gate_i) begin
      state_d = IDLE;
      shift_d = '0;
    end else if (bit_en_i) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      shift_d   = {shift_q[6:0], 1'b0};
      if (byte_end) begin
        byte_cnt_d = byte_cnt_q + 9'd1;
        case (state_q)
          PREAMBLE: begin
            if (byte_cnt_q == PRE_LAST) begin
              state_d    = SYNC;
              byte_cnt_d = '0;
              shift_d    = SYNC_BYTE;
            end
          end
          SYNC: begin
            state_d    = DATA;
            byte_cnt_d = '0;
            shift_d    = cache_q_i;
            byte_idx_d = byte_idx_inc;
          end
          DATA: begin
            if (byte_cnt_q == SECT_LAST) begin
              state_d    = POST;
              byte_cnt_d = '0;
              shift_d    = '0;
            end else begin
              shift_d    = cache_q_i;
              byte_idx_d = byte_idx_inc;
            end
          end
          POST: begin
            if (byte_cnt_q == POST_LAST) begin
              state_d    = IDLE;
              byte_cnt_d = '0;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  assign cache_addr_o     = {head_q, sector_q, byte_idx_q};
  assign read_data_o      = shift_q[7];
  assign read_valid_o     = (state_q != IDLE);
  assign busy_o           = (state_q != IDLE);
  assign sector_overrun_o = overrun_q;

`ifdef HAWK_READ_CHECKSUM_EN
  localparam logic [8:0] CKS_HI_IDX = 9'(SECTOR_BYTES - 2);

  logic [15:0] acc_q;
  logic [7:0]  cks_hi_q;
  logic        mism_q;
  logic        cks_err_q;
  logic        load_en;
  logic        post_entry;
  logic [8:0]  load_idx;

  // Index of the sector byte entering the shift register on this boundary.
  assign load_en    = byte_end & ((state_q == SYNC) | ((state_q == DATA) & (byte_cnt_q != SECT_LAST)));
  assign load_idx   = (state_q == SYNC) ? 9'd0 : byte_cnt_q + 9'd1;
  assign post_entry = byte_end & (state_q == DATA) & (byte_cnt_q == SECT_LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q     <= '0;
      cks_hi_q  <= '0;
      mism_q    <= 1'b0;
      cks_err_q <= 1'b0;
    end else if (start) begin
      acc_q     <= '0;
      mism_q    <= 1'b0;
      cks_err_q <= 1'b0;
    end else begin
      if (load_en) begin
        if (load_idx < CKS_HI_IDX) begin
          acc_q <= acc_q + {8'd0, cache_q_i};
        end else if (load_idx == CKS_HI_IDX) begin
          cks_hi_q <= cache_q_i;
        end else begin
          mism_q <= (acc_q != {cks_hi_q, cache_q_i});
        end
      end
      if (post_entry) begin
        cks_err_q <= mism_q;
      end
    end
  end

  assign checksum_err_o = cks_err_q;
`else
  assign checksum_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_hawk_sector_reader.sv
// Bench for hawk_sector_reader: a bit-stream model built from the cache contents is compared
// against the DUT every cycle, plus hand-computed literal expectations per scenario.
module tb_hawk_sector_reader;

  localparam int PRE    = 8;
  localparam int SECT   = 402;
  localparam int POSTB  = 2;
  localparam int NCELLS = (PRE + 1 + SECT + POSTB) * 8;
  localparam int DSTART = (PRE + 1) * 8;
  localparam int PSTART = (PRE + 1 + SECT) * 8;
`ifdef HAWK_READ_CHECKSUM_EN
  localparam bit CKS_EN = 1'b1;
`else
  localparam bit CKS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        bit_en = 1'b0;
  logic        sector_pulse = 1'b0;
  logic        read_gate = 1'b0;
  logic [1:0]  head = '0;
  logic [3:0]  sector = '0;
  logic [14:0] cache_addr;
  logic [7:0]  cache_q = '0;
  logic        read_data, read_valid, busy, sector_overrun, checksum_err;

  logic [7:0]  cache_mem [0:32767];
  int          errors = 0;
  int          checks = 0;
  int          period = 4;
  int          div = 0;

  hawk_sector_reader dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .bit_en_i        (bit_en),
    .sector_pulse_i  (sector_pulse),
    .read_gate_i     (read_gate),
    .head_i          (head),
    .sector_i        (sector),
    .cache_addr_o    (cache_addr),
    .cache_q_i       (cache_q),
    .read_data_o     (read_data),
    .read_valid_o    (read_valid),
    .busy_o          (busy),
    .sector_overrun_o(sector_overrun),
    .checksum_err_o  (checksum_err)
  );

  always #5 clk = ~clk;

  // Registered cache port: data valid one clk after the address.
  always @(posedge clk) cache_q <= cache_mem[cache_addr];

  initial begin
    forever begin
      @(posedge clk);
      #1;
      div = (div + 1 >= period) ? 0 : div + 1;
      bit_en = (div == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_active = 1'b0;
  logic        m_ovr = 1'b0;
  logic        m_err = 1'b0;
  logic        m_err_at_post = 1'b0;
  logic        m_pulse_prev = 1'b0;
  logic        m_rise;
  int          m_k = 0;
  int          m_begun;
  logic [14:0] m_addr = '0;
  logic [1:0]  m_head = '0;
  logic [3:0]  m_sector = '0;
  logic        exp_bits [0:NCELLS-1];

  function automatic logic [7:0] stream_byte(input int b);
    logic [14:0] base;
    base = {m_head, m_sector, 9'd0};
    if (b < PRE) return 8'h00;
    if (b == PRE) return 8'h01;
    if (b < PRE + 1 + SECT) return cache_mem[base + 15'(b - PRE - 1)];
    return 8'h00;
  endfunction

  function automatic logic [7:0] model_byte(input int b);
    logic [7:0] v;
    for (int j = 0; j < 8; j++) v[7 - j] = exp_bits[b * 8 + j];
    return v;
  endfunction

  task automatic model_start();
    int          sum;
    logic [14:0] base;
    logic [7:0]  b;
    m_head   = head;
    m_sector = sector;
    for (int i = 0; i < NCELLS; i++) begin
      b = stream_byte(i / 8);
      exp_bits[i] = b[7 - (i % 8)];
    end
    base = {m_head, m_sector, 9'd0};
    sum  = 0;
    for (int i = 0; i < SECT - 2; i++) sum += int'(cache_mem[base + 15'(i)]);
    m_err_at_post = CKS_EN &&
      (sum[15:0] != {cache_mem[base + 15'(SECT - 2)], cache_mem[base + 15'(SECT - 1)]});
    m_active = 1'b1;
    m_k      = 0;
    m_err    = 1'b0;
    m_addr   = base;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active     = 1'b0;
      m_ovr        = 1'b0;
      m_err        = 1'b0;
      m_pulse_prev = 1'b0;
      m_k          = 0;
      m_addr       = '0;
    end else begin
      m_rise       = sector_pulse && !m_pulse_prev;
      m_pulse_prev = sector_pulse;
      m_ovr        = m_rise && m_active;
      if (!m_active) begin
        if (m_rise && read_gate) model_start();
      end else if (!read_gate) begin
        m_active = 1'b0;
      end else if (bit_en) begin
        m_k++;
        if (m_k >= DSTART) begin
          m_begun = (m_k - DSTART) / 8 + 1;
          if (m_begun > SECT - 1) m_begun = SECT - 1;
          m_addr = {m_head, m_sector, 9'(m_begun)};
        end
        if (m_k == PSTART) m_err = m_err_at_post;
        if (m_k == NCELLS) m_active = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("read_valid", 32'(read_valid), 32'(m_active));
    chk("read_data", 32'(read_data), m_active ? 32'(exp_bits[m_k]) : 32'd0);
    chk("busy", 32'(busy), 32'(m_active));
    chk("sector_overrun", 32'(sector_overrun), 32'(m_ovr));
    chk("cache_addr", 32'(cache_addr), 32'(m_addr));
    chk("checksum_err", 32'(checksum_err), 32'(m_err));
  end

  // Deserializer: a cell ends at each strobe while read_valid is high.
  logic [7:0] des_sh = '0;
  int         des_n = 0;
  int         cells = 0;
  int         ovr_cnt = 0;
  logic [7:0] des_q [$];

  always @(negedge clk) begin
    if (sector_overrun) ovr_cnt++;
    if (read_valid && bit_en) begin
      cells++;
      des_sh = {des_sh[6:0], read_data};
      des_n++;
      if (des_n == 8) begin
        des_q.push_back(des_sh);
        des_n = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_des();
    des_q.delete();
    des_n   = 0;
    cells   = 0;
    ovr_cnt = 0;
  endtask

  task automatic start_sector(input logic [1:0] h, input logic [3:0] s);
    tick();
    head = h;
    sector = s;
    sector_pulse = 1'b1;
    repeat (3) tick();
    sector_pulse = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_k(input int target, input int budget);
    int n;
    n = 0;
    while (!(m_active && m_k >= target) && n < budget) begin
      tick();
      n++;
    end
    chk("wait_k_timeout", 32'(n < budget), 32'd1);
  endtask

  task automatic fill_cks(input logic [14:0] base);
    int sum;
    sum = 0;
    for (int i = 0; i < SECT - 2; i++) sum += int'(cache_mem[base + 15'(i)]);
    cache_mem[base + 15'(SECT - 2)] = sum[15:8];
    cache_mem[base + 15'(SECT - 1)] = sum[7:0];
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_read_data"}, 32'(read_data), 32'd0);
    chk({tag, "_read_valid"}, 32'(read_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_overrun"}, 32'(sector_overrun), 32'd0);
    chk({tag, "_cache_addr"}, 32'(cache_addr), 32'd0);
    chk({tag, "_checksum_err"}, 32'(checksum_err), 32'd0);
  endtask

  initial begin
    logic [14:0] base_a;
    logic [14:0] base_b;
    int          n;
    int          bad;

    base_a = {2'd2, 4'd5, 9'd0};
    base_b = {2'd1, 4'd9, 9'd0};
    for (int i = 0; i < 32768; i++) cache_mem[i] = 8'h00;
    for (int i = 0; i < SECT - 2; i++) cache_mem[base_a + 15'(i)] = 8'(i);
    fill_cks(base_a);

    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    read_gate = 1'b1;
    repeat (2) tick();

    // Full sector, head 2 / sector 5, strobe every 4 clk.
    clear_des();
    start_sector(2'd2, 4'd5);
    chk("addr_first", 32'(cache_addr), 32'h4A00);
    chk("model_sync", 32'(model_byte(PRE)), 32'h01);
    chk("model_cks_hi", 32'(model_byte(PRE + 1 + 400)), 32'hA7);
    chk("model_cks_lo", 32'(model_byte(PRE + 1 + 401)), 32'hB8);
    wait_idle(20000, "t1_done");
    chk("t1_cells", 32'(cells), 32'd3304);
    chk("t1_bytes", 32'(des_q.size()), 32'd413);
    if (des_q.size() == 413) begin
      chk("t1_pre_last", 32'(des_q[7]), 32'h00);
      chk("t1_sync", 32'(des_q[8]), 32'h01);
      chk("t1_byte0", 32'(des_q[9]), 32'h00);
      chk("t1_byte145", 32'(des_q[154]), 32'h91);
      chk("t1_byte399", 32'(des_q[408]), 32'h8F);
      chk("t1_byte400", 32'(des_q[409]), 32'hA7);
      chk("t1_byte401", 32'(des_q[410]), 32'hB8);
      chk("t1_post", 32'(des_q[411]), 32'h00);
    end
    chk("t1_addr_hold", 32'(cache_addr), 32'h4B91);
    tick();
    chk("t1_addr_hold_idle", 32'(cache_addr), 32'h4B91);

    // read_gate dropped during data byte 100.
    period = 2;
    clear_des();
    start_sector(2'd2, 4'd5);
    wait_k(DSTART + 100 * 8, 4000);
    read_gate = 1'b0;
    tick();
    chk("gate_read_valid", 32'(read_valid), 32'd0);
    chk("gate_read_data", 32'(read_data), 32'd0);
    chk("gate_busy", 32'(busy), 32'd0);
    read_gate = 1'b1;
    repeat (4) tick();

    // Clean restart; overrun mid-data and overrun coinciding with the last postamble bit.
    clear_des();
    start_sector(2'd2, 4'd5);
    wait_k(DSTART + 50 * 8, 4000);
    sector_pulse = 1'b1;
    repeat (2) tick();
    sector_pulse = 1'b0;
    n = 0;
    while (!(bit_en && m_active && m_k == NCELLS - 1) && n < 10000) begin
      tick();
      n++;
    end
    chk("lastbit_found", 32'(n < 10000), 32'd1);
    sector_pulse = 1'b1;
    repeat (20) tick();
    sector_pulse = 1'b0;
    chk("t3_overruns", 32'(ovr_cnt), 32'd2);
    chk("t3_idle_after", 32'(busy), 32'd0);
    chk("t3_bytes", 32'(des_q.size()), 32'd413);
    if (des_q.size() == 413) chk("t3_sync", 32'(des_q[8]), 32'h01);
    tick();

    // Reset in the middle of SYNC.
    period = 3;
    clear_des();
    start_sector(2'd2, 4'd5);
    wait_k(DSTART - 5, 2000);
    #1 rst_n = 1'b0;
    #1;
    chk_outputs_zero("midsync_rst");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Sector with checksum LSB corrupted by +1.
    cache_mem[base_a + 15'(SECT - 1)] = cache_mem[base_a + 15'(SECT - 1)] + 8'd1;
    clear_des();
    start_sector(2'd2, 4'd5);
    wait_idle(15000, "t5_done");
    chk("t5_bytes", 32'(des_q.size()), 32'd413);
    if (des_q.size() == 413) chk("t5_byte401", 32'(des_q[410]), 32'hB9);
    chk("t5_checksum_err", 32'(checksum_err), 32'(CKS_EN));
    tick();

    // Random data, minimum strobe spacing, correct checksum.
    for (int i = 0; i < SECT - 2; i++) cache_mem[base_b + 15'(i)] = 8'($urandom_range(0, 255));
    fill_cks(base_b);
    period = 2;
    clear_des();
    start_sector(2'd1, 4'd9);
    wait_idle(10000, "t6_done");
    chk("t6_bytes", 32'(des_q.size()), 32'd413);
    if (des_q.size() == 413) begin
      bad = 0;
      for (int i = 0; i < SECT; i++) if (des_q[9 + i] !== cache_mem[base_b + 15'(i)]) bad++;
      chk("t6_byte_mismatches", 32'(bad), 32'd0);
    end
    chk("t6_checksum_err", 32'(checksum_err), 32'd0);
    chk("t6_addr_hold", 32'(cache_addr), 32'h3391);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
